spi_cfg_ctrl: RTL

SPI_CFG_CTRL -- requirements
Module: spi_cfg_ctrl

---
 rtl/spi_cfg_pkg.sv | 22 ++
 rtl/spi_byte_timeout.sv | 32 +++
 rtl/spi_cfg_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration frame decoder.
// Contents: FSM state enum, default frame start marker, frame length,
// and the frame checksum helper.
package spi_cfg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StGetAddr,
      StGetData,
      StGetChk
   } cfg_state_e;

   localparam logic [7:0]  DefaultSyncByte = 8'hA5;
   localparam int unsigned FrameLen        = 4;  // SYNC, ADDR, DATA, CHK

   function automatic logic [7:0] frame_chk(input logic [7:0] sync_byte,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
      return sync_byte ^ addr ^ data;
   endfunction

endpackage

// File: rtl/spi_byte_timeout.sv
// Inter-byte watchdog for the configuration frame decoder.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   clear     - restart the count (a byte was received)
//   enable    - count only while a frame is in progress; held at zero otherwise
//   expired   - high once TIMEOUT_CYC cycles have passed without a clear
module spi_byte_timeout #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear || !enable) begin
         cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = enable && (cnt_q == CntMax);

endmodule

// File: rtl/spi_cfg_ctrl.sv
// Configuration register bank written by SPI frames SYNC, ADDR, DATA, CHK
// with CHK = SYNC ^ ADDR ^ DATA.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   byte_valid        - one-cycle strobe qualifying byte_data
//   byte_data         - received byte
//   frame_active      - synchronized chip-select active level
//   cfg_regs          - flattened register bank, register i at [8i+7:8i]
//   cfg_upd           - one-cycle pulse after a register write
//   cfg_addr          - index of the last register written
//   err_cnt           - saturating count of rejected frames
//   busy              - FSM is not idle
module spi_cfg_ctrl
   import spi_cfg_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE   = DefaultSyncByte,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   input  logic                  frame_active,
   output logic [8*NUM_REGS-1:0] cfg_regs,
   output logic                  cfg_upd,
   output logic [2:0]            cfg_addr,
   output logic [7:0]            err_cnt,
   output logic                  busy
);

   cfg_state_e state_q, state_d;
   logic [2:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [NUM_REGS-1:0][7:0] regs_q;
   logic       upd_q;
   logic [2:0] cfg_addr_q;
   logic [7:0] err_cnt_q;
   logic       expired;
   logic       abort;
   logic       addr_ok;
   logic       err_inc;
   logic       wr_en;

   spi_byte_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (byte_valid),
      .enable  (state_q != StIdle),
      .expired (expired)
   );

   assign addr_ok = (byte_data[7:3] == 5'd0) && (32'(byte_data) < NUM_REGS);
   // Abort wins over any byte arriving in the same cycle.
   assign abort   = (state_q != StIdle) && (!frame_active || expired);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_inc = 1'b0;
      wr_en   = 1'b0;
      if (abort) begin
         state_d = StIdle;
         err_inc = 1'b1;
      end else if (byte_valid) begin
         unique case (state_q)
            StIdle: begin
               // A SYNC seen while chip-select is inactive is line noise.
               if (frame_active && byte_data == SYNC_BYTE) state_d = StGetAddr;
            end
            StGetAddr: begin
               if (addr_ok) begin
                  addr_d  = byte_data[2:0];
                  state_d = StGetData;
               end else begin
                  state_d = StIdle;
                  err_inc = 1'b1;
               end
            end
            StGetData: begin
               data_d  = byte_data;
               state_d = StGetChk;
            end
            StGetChk: begin
               state_d = StIdle;
               if (byte_data == frame_chk(SYNC_BYTE, {5'd0, addr_q}, data_q)) begin
                  wr_en = 1'b1;
               end else begin
                  err_inc = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         data_q     <= '0;
         regs_q     <= '0;
         upd_q      <= 1'b0;
         cfg_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         upd_q   <= wr_en;
         if (wr_en) cfg_addr_q <= addr_q;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && addr_q == 3'(i)) regs_q[i] <= data_q;
         end
         if (err_inc && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign cfg_regs = regs_q;
   assign cfg_upd  = upd_q;
   assign cfg_addr = cfg_addr_q;
   assign err_cnt  = err_cnt_q;
   assign busy     = (state_q != StIdle);

endmodule
